// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a load/store master and the data-memory responder.
`timescale 1ns/1ps
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a ready/valid port, WAIT wait states per access.
// Optional build macro DMEM_ALIGN_CHECK_EN: accesses with addr[1:0] != 0 respond with err=1.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          ready_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          lat_we;
  logic          lat_bad;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;

  logic [31:0]   mem [DEPTH];

  logic          req_bad;
  logic          acc_we;
  logic          acc_bad;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          go_resp;
  logic          commit;

  // Any address bit above the word index makes the access out of range; no aliasing.
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_bad = (bus.addr[31:AW+2] != '0) || (bus.addr[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign req_bad    = (bus.addr[31:AW+2] != '0);
  assign unused_lsb = ^bus.addr[1:0];
`endif

  // With WAIT=0 the access completes on the accept edge itself, so it must use the live bus.
  always_comb begin
    acc_we    = lat_we;
    acc_bad   = lat_bad;
    acc_idx   = lat_idx;
    acc_wdata = lat_wdata;
    go_resp   = 1'b0;
    if (state == ST_IDLE) begin
      acc_we    = bus.we;
      acc_bad   = req_bad;
      acc_idx   = bus.addr[AW+1:2];
      acc_wdata = bus.wdata;
      go_resp   = bus.req && (WAIT == 0);
    end else if (state == ST_WAIT) begin
      go_resp   = (cnt == 4'd0);
    end
  end

  assign commit = go_resp && acc_we && !acc_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_bad   <= req_bad;
            lat_idx   <= bus.addr[AW+1:2];
            lat_wdata <= bus.wdata;
            ready_q   <= 1'b0;
            if (WAIT > 0) begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
      if (go_resp) begin
        state    <= ST_RESP;
        rvalid_q <= 1'b1;
        rdata_q  <= (acc_we || acc_bad) ? 32'd0 : mem[acc_idx];
        err_q    <= acc_bad;
      end
    end
  end

  // Storage is deliberately unreset; gating on reset keeps an aborted transaction from landing.
  always_ff @(posedge clk) begin
    if (commit && reset) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench driving a WAIT=2 and a WAIT=0 responder with directed vectors.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_if busA ();
  dmem_if busB ();

  dmem_responder #(.DEPTH(64), .WAIT(2)) dutA (.clk(clk), .reset(reset), .bus(busA));
  dmem_responder #(.DEPTH(64), .WAIT(0)) dutB (.clk(clk), .reset(reset), .bus(busB));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t expA[$];
  exp_t expB[$];
  int   accA[$];
  int   accB[$];
  int   cyc = 0;
  int   nCompared = 0;
  int   nFailed = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    nCompared++;
    if (act !== req) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, req);
    end
  endtask

  // Latency is counted in negedges from the accept cycle to the rvalid cycle: WAIT+1.
  task automatic checkOutput(input int d, input logic [31:0] rdata, input logic err);
    exp_t e;
    int   acc;
    int   lat;
    lat = (d == 0) ? 3 : 1;
    if ((d == 0 && (expA.size() == 0 || accA.size() == 0)) ||
        (d == 1 && (expB.size() == 0 || accB.size() == 0))) begin
      nCompared++;
      nFailed++;
      $display("[TB] FAIL unexpected rvalid on dut%0d: got rdata 0x%08h, wanted no response", d, rdata);
    end else begin
      if (d == 0) begin
        e   = expA.pop_front();
        acc = accA.pop_front();
      end else begin
        e   = expB.pop_front();
        acc = accB.pop_front();
      end
      compare({e.name, " rdata"}, rdata, e.rdata);
      compare({e.name, " err"}, {31'd0, err}, {31'd0, e.err});
      compare({e.name, " latency"}, 32'(cyc - acc), 32'(lat));
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      accA.delete();
      accB.delete();
    end else begin
      if (busA.rvalid) checkOutput(0, busA.rdata, busA.err);
      if (busB.rvalid) checkOutput(1, busB.rdata, busB.err);
      if (busA.req && busA.ready) accA.push_back(cyc);
      if (busB.req && busB.ready) accB.push_back(cyc);
    end
  end

  task automatic setBus(input int d, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    if (d == 0) begin
      busA.req = req; busA.we = we; busA.addr = addr; busA.wdata = wdata;
    end else begin
      busB.req = req; busB.we = we; busB.addr = addr; busB.wdata = wdata;
    end
  endtask

  function automatic logic isIdle(input int d);
    if (d == 0) return busA.ready && (expA.size() == 0);
    return busB.ready && (expB.size() == 0);
  endfunction

  task automatic waitIdle(input int d);
    int n = 0;
    while (n < 100 && !isIdle(d)) begin
      @(posedge clk); #2;
      n++;
    end
    if (!isIdle(d)) begin
      nCompared++;
      nFailed++;
      $display("[TB] FAIL timeout dut%0d: got %0d responses outstanding, wanted 0",
               d, (d == 0) ? expA.size() : expB.size());
      if (d == 0) expA.delete(); else expB.delete();
    end
  endtask

  task automatic pushExp(input int d, input logic [31:0] rdata, input logic err, input string name);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.name  = name;
    if (d == 0) expA.push_back(e); else expB.push_back(e);
  endtask

  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata,
                               input logic expErr, input string name);
    waitIdle(d);
    pushExp(d, expRdata, expErr, name);
    setBus(d, 1'b1, we, addr, wdata);
    @(posedge clk); #2;
    setBus(d, 1'b0, 1'b0, 32'd0, 32'd0);
    waitIdle(d);
  endtask

  task automatic checkResetValues(input string name);
    compare({name, " A ready"},  {31'd0, busA.ready},  32'd1);
    compare({name, " A rvalid"}, {31'd0, busA.rvalid}, 32'd0);
    compare({name, " A rdata"},  busA.rdata,           32'd0);
    compare({name, " A err"},    {31'd0, busA.err},    32'd0);
    compare({name, " B ready"},  {31'd0, busB.ready},  32'd1);
    compare({name, " B rvalid"}, {31'd0, busB.rvalid}, 32'd0);
    compare({name, " B rdata"},  busB.rdata,           32'd0);
    compare({name, " B err"},    {31'd0, busB.err},    32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    setBus(0, 1'b0, 1'b0, 32'd0, 32'd0);
    setBus(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkResetValues("in reset");
    @(posedge clk); #2;
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("after release");
    @(posedge clk); #2;

    $display("[TB] write/read, WAIT=2");
    applyStimulus(0, 1'b1, 32'h0000_0000, 32'h0102_0304, 32'd0, 1'b0, "wr 0x0");
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, "wr 0x10");
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd 0x10");
    applyStimulus(0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'd0, 1'b0, "wr last word");
    applyStimulus(0, 1'b0, 32'h0000_00FC, 32'd0, 32'hCAFE_F00D, 1'b0, "rd last word");

    $display("[TB] out-of-range accesses");
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'h1111_2222, 32'd0, 1'b1, "wr 0x100");
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 1'b1, "rd 0x100");
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'd0, 32'h0102_0304, 1'b0, "rd 0x0 after oor");
    applyStimulus(0, 1'b1, 32'h8000_0010, 32'h5555_5555, 32'd0, 1'b1, "wr high alias");
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd 0x10 after alias");

    $display("[TB] misaligned read 0x11");
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(0, 1'b0, 32'h0000_0011, 32'd0, 32'd0, 1'b1, "rd misaligned");
`else
    applyStimulus(0, 1'b0, 32'h0000_0011, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd misaligned");
`endif

    $display("[TB] reset during a pending write");
    applyStimulus(0, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'd0, 1'b0, "prewr 0x20");
    setBus(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #2;
    setBus(0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetValues("mid-write reset");
    end
    @(posedge clk); #2;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'd0, 32'hAAAA_5555, 1'b0, "rd 0x20 after abort");

    $display("[TB] WAIT=0 back-to-back reads");
    applyStimulus(1, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'd0, 1'b0, "B wr 0x0");
    applyStimulus(1, 1'b0, 32'h0000_0200, 32'd0, 32'd0, 1'b1, "B rd oor");
    waitIdle(1);
    for (int i = 0; i < 4; i++) pushExp(1, 32'h0BAD_F00D, 1'b0, "B held rd 0x0");
    setBus(1, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compare("B ready toggle", {31'd0, busB.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #2;
    end
    setBus(1, 1'b0, 1'b0, 32'd0, 32'd0);
    waitIdle(1);
    waitIdle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
